uart_tx_fifo_drain: RTL and testbench



---
 rtl/uart_tx_fifo_drain.sv | 157 +++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a FIFO read port: pops one word per frame and sends it LSB first
// with optional parity and one or two stop bits, idling high when the FIFO is empty.
module uart_tx_fifo_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        baud_cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [DATA_WIDTH-1:0]   shift;
    logic [DATA_WIDTH-1:0]   shift_next;
    logic                    parity_acc;

    assign shift_next = shift >> 1;

    function automatic logic parity_bit(input logic acc);
        return acc ^ PARITY_ODD[0];
    endfunction

    // bit_idx counts data bits in DATA and stop bits in STOP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            parity_acc <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (tx_enable && !fifo_empty) begin
                        state      <= POP;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                POP: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shift      <= fifo_dout;
                    parity_acc <= 1'b0;
                    baud_cnt   <= '0;
                    bit_idx    <= '0;
                    tx         <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt   <= '0;
                        shift      <= shift_next;
                        parity_acc <= parity_acc ^ shift[0];
                        if (bit_idx == IDX_DATA_LAST) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= parity_bit(parity_acc ^ shift[0]);
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx      <= shift_next[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    // Raised one cycle early so the pulse occupies the final stop cycle
                    if (baud_cnt == CNT_PRE_LAST && bit_idx == IDX_STOP_LAST) begin
                        tx_done <= 1'b1;
                    end
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_STOP_LAST) begin
                            bit_idx <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench: four transmitter variants (8N1, 8E1, 8O1, 8N2) at 4 clocks per bit,
// each fed by a small behavioural FIFO.
module tb_uart_tx_fifo_drain;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] tx_en = 4'b1111;
    logic [3:0] fifo_empty;
    logic [7:0] fifo_dout [4];
    logic [3:0] rd_en;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [3:0] done;

    logic [7:0] mem [4][16];
    int         wp [4];
    int         rp [4];
    int         rd_cnt [4];
    int         rd_cyc [4];
    int         done_cnt [4];
    int         done_cyc [4];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_fifo_drain #(
            .DATA_WIDTH  (8),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD  ((g == 2) ? 1 : 0),
            .STOP_BITS   ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .tx_enable (tx_en[g]),
            .fifo_empty(fifo_empty[g]),
            .fifo_dout (fifo_dout[g]),
            .fifo_rd_en(rd_en[g]),
            .tx        (tx[g]),
            .busy      (busy[g]),
            .tx_done   (done[g])
        );
        assign fifo_empty[g] = (wp[g] == rp[g]);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            wp[i] = 0; rp[i] = 0; rd_cnt[i] = 0; rd_cyc[i] = 0;
            done_cnt[i] = 0; done_cyc[i] = 0; fifo_dout[i] = 8'h00;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (rd_en[i]) begin
                fifo_dout[i] <= mem[i][rp[i] % 16];
                rp[i]        <= rp[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rd_en[i] === 1'b1) begin
                rd_cnt[i] = rd_cnt[i] + 1;
                rd_cyc[i] = cyc;
            end
            if (done[i] === 1'b1) begin
                done_cnt[i] = done_cnt[i] + 1;
                done_cyc[i] = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d);
        mem[i][wp[i] % 16] = d;
        wp[i] = wp[i] + 1;
    endtask

    // Called at a negedge; waits for the start bit, then samples every cycle of nbits bit periods.
    task automatic capture(input int i, input int nbits, input int drop_at,
                           output logic [15:0] bits, output logic held, output int st);
        int   t;
        int   c;
        logic v;
        t    = 0;
        bits = '0;
        held = 1'b1;
        while (tx[i] !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        st = cyc;
        if (t >= 3000) begin
            check("start_bit_timeout", 32'(t), 32'd0);
            held = 1'b0;
            return;
        end
        c = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < CPB; k++) begin
                if (c == drop_at) tx_en[i] = 1'b0;
                v = tx[i];
                if (k == 0) bits[b] = v;
                else if (v !== bits[b]) held = 1'b0;
                c++;
                @(negedge clk);
            end
        end
    endtask

    logic [15:0] bits;
    logic        held;
    int          st1, st2, st3;
    int          rd0, dn0;
    logic        saw_low;

    initial begin
        push(0, 8'hA5);
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx[0]), 32'd1);
        check("reset_busy", 32'(busy[0]), 32'd0);
        check("reset_done", 32'(done[0]), 32'd0);
        check("reset_no_pop", 32'(rd_cnt[0]), 32'd0);
        rst_n = 1'b1;

        capture(0, 10, -1, bits, held, st1);
        check("a5_bits", 32'(bits[9:0]), 32'({1'b1, 8'hA5, 1'b0}));
        check("a5_bit_hold", 32'(held), 32'd1);
        check("a5_pop_count", 32'(rd_cnt[0]), 32'd1);
        check("a5_pop_to_start", 32'(st1 - rd_cyc[0]), 32'd2);
        check("a5_done_count", 32'(done_cnt[0]), 32'd1);
        check("a5_done_cycle", 32'(done_cyc[0] - st1 + 1), 32'd40);

        rd0 = rd_cnt[0];
        push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C);
        capture(0, 10, -1, bits, held, st1);
        check("b2b_00", 32'(bits[9:0]), 32'({1'b1, 8'h00, 1'b0}));
        capture(0, 10, -1, bits, held, st2);
        check("b2b_ff", 32'(bits[9:0]), 32'({1'b1, 8'hFF, 1'b0}));
        capture(0, 10, -1, bits, held, st3);
        check("b2b_3c", 32'(bits[9:0]), 32'({1'b1, 8'h3C, 1'b0}));
        check("b2b_gap1", 32'(st2 - st1 - 40), 32'd3);
        check("b2b_gap2", 32'(st3 - st2 - 40), 32'd3);
        repeat (5) @(negedge clk);
        check("b2b_pops", 32'(rd_cnt[0] - rd0), 32'd3);
        check("b2b_busy_after", 32'(busy[0]), 32'd0);

        push(1, 8'hA5);
        capture(1, 11, -1, bits, held, st1);
        check("even_a5", 32'(bits[10:0]), 32'({1'b1, 1'b0, 8'hA5, 1'b0}));
        check("even_a5_len", 32'(done_cyc[1] - st1 + 1), 32'd44);
        push(2, 8'hA5);
        capture(2, 11, -1, bits, held, st1);
        check("odd_a5", 32'(bits[10:0]), 32'({1'b1, 1'b1, 8'hA5, 1'b0}));
        check("odd_a5_len", 32'(done_cyc[2] - st1 + 1), 32'd44);
        push(1, 8'h01);
        capture(1, 11, -1, bits, held, st1);
        check("even_01", 32'(bits[10:0]), 32'({1'b1, 1'b1, 8'h01, 1'b0}));
        check("even_hold", 32'(held), 32'd1);

        push(3, 8'h80);
        capture(3, 11, -1, bits, held, st1);
        check("stop2_80", 32'(bits[10:0]), 32'({1'b1, 1'b1, 8'h80, 1'b0}));
        check("stop2_hold", 32'(held), 32'd1);
        check("stop2_done_cycle", 32'(done_cyc[3] - st1 + 1), 32'd44);
        check("stop2_done_count", 32'(done_cnt[3]), 32'd1);

        tx_en[0] = 1'b0;
        rd0 = rd_cnt[0];
        dn0 = done_cnt[0];
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
        saw_low = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) saw_low = 1'b1;
        end
        check("gated_tx_high", 32'(saw_low), 32'd0);
        check("gated_no_pop", 32'(rd_cnt[0] - rd0), 32'd0);
        tx_en[0] = 1'b1;
        capture(0, 10, 8, bits, held, st1);
        check("drop_frame_11", 32'(bits[9:0]), 32'({1'b1, 8'h11, 1'b0}));
        repeat (100) @(negedge clk);
        check("drop_single_pop", 32'(rd_cnt[0] - rd0), 32'd1);
        check("drop_done_once", 32'(done_cnt[0] - dn0), 32'd1);
        check("drop_idle_busy", 32'(busy[0]), 32'd0);
        check("drop_idle_tx", 32'(tx[0]), 32'd1);

        tx_en[0] = 1'b1;
        st1 = 0;
        while (tx[0] !== 1'b0 && st1 < 3000) begin
            @(negedge clk);
            st1++;
        end
        check("rst_mid_start_seen", 32'(tx[0]), 32'd0);
        repeat (17) @(negedge clk);
        check("rst_mid_bit3", 32'(tx[0]), 32'd0);
        check("rst_mid_busy", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        wp[0] = rp[0];
        @(negedge clk);
        check("rst_mid_tx", 32'(tx[0]), 32'd1);
        check("rst_mid_busy_clr", 32'(busy[0]), 32'd0);
        rd0 = rd_cnt[0];
        @(negedge clk);
        rst_n = 1'b1;
        saw_low = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) saw_low = 1'b1;
        end
        check("rst_empty_idle", 32'(saw_low), 32'd0);
        check("rst_empty_no_pop", 32'(rd_cnt[0] - rd0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
